// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, NOP address and arbiter state encoding
package sdram_pkg;

    // {CKE, CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [4:0] CMD_NOP   = 5'b10111;
    localparam logic [4:0] CMD_PREC  = 5'b10010;
    localparam logic [4:0] CMD_ACT   = 5'b10011;
    localparam logic [4:0] CMD_READ  = 5'b10101;
    localparam logic [4:0] CMD_WRITE = 5'b10100;
    localparam logic [4:0] CMD_AREF  = 5'b10001;

    // A10 high on idle cycles keeps any stray precharge an all-bank one
    localparam logic [11:0] NOP_ADDR = 12'h400;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - refresh interval counter with pending and sticky overrun flags
module sdram_ref_timer #(
    parameter int REF_PERIOD = 1500,
    parameter int REF_W      = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic aref_end,
    output logic ref_pend,
    output logic ref_overrun
);

    localparam logic [REF_W-1:0] LAST = REF_W'(REF_PERIOD - 1);

    logic [REF_W-1:0] cnt_q;
    logic             pend_q;
    logic             overrun_q;
    logic             wrap;

    assign wrap        = run && (cnt_q == LAST);
    assign ref_pend    = pend_q;
    assign ref_overrun = overrun_q;

    // Interval counter; a wrap raises the pending flag and outranks a same-cycle completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (run) begin
                cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            end
            if (wrap) begin
                pend_q <= 1'b1;
            end else if (aref_end) begin
                pend_q <= 1'b0;
            end
            if (wrap && pend_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - grants the SDRAM command bus to init, refresh, write or read sequencer
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = 1500,
    parameter int REF_W      = 11
) (
    input  logic        S_CLK,
    input  logic        RST,
    input  logic        init_done,
    input  logic [4:0]  init_cmd,
    input  logic [11:0] init_addr,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [4:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    output logic        aref_req,
    input  logic        wr_req,
    output logic        write_en,
    input  logic        write_end,
    input  logic [4:0]  write_cmd,
    input  logic [11:0] write_addr,
    input  logic        rd_req,
    output logic        read_en,
    input  logic        read_end,
    input  logic [4:0]  read_cmd,
    input  logic [11:0] read_addr,
    output logic [4:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic        ref_overrun
);

    state_t state_q;
    logic   last_grant_q;    // 0: write was granted last, 1: read was granted last
    logic   ref_pend;
    logic   ref_run;
    logic   aref_end_ok;

    // The counter starts in the same cycle init_done is seen, before ARBIT is entered
    assign ref_run     = (state_q != ST_INIT) || init_done;
    // Only a completion from the active refresh sequence may clear the pending flag
    assign aref_end_ok = aref_end && (state_q == ST_AREF);

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD),
        .REF_W      (REF_W)
    ) u_timer (
        .clk         (S_CLK),
        .rst         (RST),
        .run         (ref_run),
        .aref_end    (aref_end_ok),
        .ref_pend    (ref_pend),
        .ref_overrun (ref_overrun)
    );

    // Arbitration FSM: init first, then refresh, then round-robin between write and read
    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_INIT;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_done) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (ref_pend) begin
                        state_q <= ST_AREF;
                    end else if (wr_req && rd_req) begin
                        state_q      <= last_grant_q ? ST_WRITE : ST_READ;
                        last_grant_q <= ~last_grant_q;
                    end else if (wr_req) begin
                        state_q      <= ST_WRITE;
                        last_grant_q <= 1'b0;
                    end else if (rd_req) begin
                        state_q      <= ST_READ;
                        last_grant_q <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_WRITE: begin
                    if (write_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_READ: begin
                    if (read_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Grants decode from the state; a pending refresh pulls the data grant so the burst winds down
    assign aref_req = ref_pend;
    assign aref_en  = (state_q == ST_AREF);
    assign write_en = (state_q == ST_WRITE) && wr_req && !ref_pend;
    assign read_en  = (state_q == ST_READ) && rd_req && !ref_pend;

    // Device bus follows whichever sequencer owns the state; ARBIT drives NOP
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = NOP_ADDR;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = write_cmd;
                sdram_addr = write_addr;
            end
            ST_READ: begin
                sdram_cmd  = read_cmd;
                sdram_addr = read_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = NOP_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int RP = 100;
    localparam logic [11:0] AREF_A  = 12'h0ab;
    localparam logic [11:0] WRITE_A = 12'h2c5;
    localparam logic [11:0] READ_A  = 12'h3d6;

    logic        S_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        init_done = 1'b0;
    logic [4:0]  init_cmd = CMD_NOP;
    logic [11:0] init_addr = NOP_ADDR;
    logic        aref_en;
    logic        aref_end = 1'b0;
    logic [4:0]  aref_cmd = CMD_AREF;
    logic [11:0] aref_addr = AREF_A;
    logic        aref_req;
    logic        wr_req = 1'b0;
    logic        write_en;
    logic        write_end = 1'b0;
    logic [4:0]  write_cmd = CMD_WRITE;
    logic [11:0] write_addr = WRITE_A;
    logic        rd_req = 1'b0;
    logic        read_en;
    logic        read_end = 1'b0;
    logic [4:0]  read_cmd = CMD_READ;
    logic [11:0] read_addr = READ_A;
    logic [4:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic        ref_overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int t_init = 0;
    int t_ref = 0;

    logic [16:0] bus_q[$];
    logic        grant_q[$];

    sdram_arbiter #(.REF_PERIOD(RP), .REF_W(7)) dut (
        .S_CLK(S_CLK), .RST(RST), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_req(aref_req),
        .wr_req(wr_req), .write_en(write_en), .write_end(write_end),
        .write_cmd(write_cmd), .write_addr(write_addr),
        .rd_req(rd_req), .read_en(read_en), .read_end(read_end),
        .read_cmd(read_cmd), .read_addr(read_addr),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .ref_overrun(ref_overrun)
    );

    always #5 S_CLK = ~S_CLK;
    always @(posedge S_CLK) cyc <= cyc + 1;

    task automatic tick;
        @(posedge S_CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic wait_ref_rise(input int base, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 150 && !found; k++) begin
            tick; settle;
            if (aref_req === 1'b1) begin
                found = 1'b1;
                t_ref = cyc;
            end
        end
        tests_run++;
        if (!found || (t_ref - base) != RP) begin
            tests_failed++;
            $display("FAIL %s: aref_req rose %0d cycles after base (found=%0b), want %0d", name, t_ref - base, found, RP);
        end
    endtask

    task automatic service_aref(input string name);
        tick; settle;
        tests_run++;
        if (aref_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: aref_en=%b one cycle after aref_req, want 1", name, aref_en);
        end
        aref_end = 1'b1;
        tick;
        aref_end = 1'b0;
        settle;
    endtask

    task automatic test_reset;
        repeat (3) tick;
        settle;
        tests_run++;
        if ({aref_en, write_en, read_en, aref_req, ref_overrun} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, want 00000", {aref_en, write_en, read_en, aref_req, ref_overrun});
        end
        tests_run++;
        if ({sdram_cmd, sdram_addr} !== {CMD_NOP, NOP_ADDR}) begin
            tests_failed++;
            $display("FAIL reset_bus: got %b/%h, want %b/%h", sdram_cmd, sdram_addr, CMD_NOP, NOP_ADDR);
        end
    endtask

    task automatic test_init;
        logic [16:0] exp;
        tick;
        RST = 1'b0;
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) tick;
            if (i <= 10) begin
                init_cmd  = (i % 2 == 1) ? CMD_AREF : CMD_PREC;
                init_addr = 12'h100 + 12'(i);
                bus_q.push_back({init_cmd, init_addr});
            end else begin
                bus_q.push_back({CMD_NOP, NOP_ADDR});
            end
            if (i == 10) begin
                init_done = 1'b1;
                t_init = cyc;
            end
            settle;
            exp = bus_q.pop_front();
            tests_run++;
            if ({sdram_cmd, sdram_addr} !== exp) begin
                tests_failed++;
                $display("FAIL init_bus[%0d]: got %b/%h, want %b/%h", i, sdram_cmd, sdram_addr, exp[16:12], exp[11:0]);
            end
        end
    endtask

    task automatic test_refresh_idle;
        wait_ref_rise(t_init, "ref_first_interval");
        tick; settle;
        tests_run++;
        if ({aref_en, write_en, read_en, sdram_cmd, sdram_addr} !== {3'b100, CMD_AREF, AREF_A}) begin
            tests_failed++;
            $display("FAIL aref_grant: en=%b%b%b bus=%b/%h, want 100 %b/%h", aref_en, write_en, read_en, sdram_cmd, sdram_addr, CMD_AREF, AREF_A);
        end
        write_end = 1'b1;
        tick;
        write_end = 1'b0;
        settle;
        tests_run++;
        if (aref_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL stray_write_end: aref_en=%b, want 1", aref_en);
        end
        aref_end = 1'b1;
        tick;
        aref_end = 1'b0;
        settle;
        tests_run++;
        if ({aref_en, aref_req, sdram_cmd, sdram_addr} !== {2'b00, CMD_NOP, NOP_ADDR}) begin
            tests_failed++;
            $display("FAIL aref_end_clear: en/req=%b%b bus=%b/%h, want 00 NOP/400", aref_en, aref_req, sdram_cmd, sdram_addr);
        end
        wait_ref_rise(t_ref, "ref_second_interval");
        service_aref("aref_second_grant");
    endtask

    task automatic test_back_to_back;
        int   run_len = 0;
        int   done = 0;
        bit   prev_end = 1'b0;
        logic exp_g;
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int k = 0; k < 60 && done < 4; k++) begin
            tick;
            write_end = 1'b0;
            read_end  = 1'b0;
            settle;
            tests_run++;
            if ($countones({aref_en, write_en, read_en}) > 1) begin
                tests_failed++;
                $display("FAIL grant_exclusive: en=%b%b%b, want at most one", aref_en, write_en, read_en);
            end
            if (prev_end) begin
                tests_run++;
                if ({write_en, read_en, sdram_cmd} !== {2'b00, CMD_NOP}) begin
                    tests_failed++;
                    $display("FAIL turnaround_nop: en=%b%b cmd=%b, want 00 %b", write_en, read_en, sdram_cmd, CMD_NOP);
                end
            end
            prev_end = 1'b0;
            if (write_en || read_en) begin
                run_len++;
                if (run_len == 1 && grant_q.size() > 0) begin
                    exp_g = grant_q.pop_front();
                    tests_run++;
                    if (read_en !== exp_g) begin
                        tests_failed++;
                        $display("FAIL rr_order: got %s grant, want %s", read_en ? "read" : "write", exp_g ? "read" : "write");
                    end
                end
                tests_run++;
                if ({sdram_cmd, sdram_addr} !== (write_en ? {CMD_WRITE, WRITE_A} : {CMD_READ, READ_A})) begin
                    tests_failed++;
                    $display("FAIL data_bus: got %b/%h with en=%b%b", sdram_cmd, sdram_addr, write_en, read_en);
                end
                if (run_len == 3) begin
                    if (write_en) write_end = 1'b1;
                    else          read_end  = 1'b1;
                    prev_end = 1'b1;
                    run_len  = 0;
                    done++;
                    if (done == 4) begin
                        wr_req = 1'b0;
                        rd_req = 1'b0;
                    end
                end
            end
        end
        tick;
        write_end = 1'b0;
        read_end  = 1'b0;
        settle;
        tests_run++;
        if (done != 4 || grant_q.size() != 0 || {write_en, read_en, sdram_cmd} !== {2'b00, CMD_NOP}) begin
            tests_failed++;
            $display("FAIL rr_complete: grants=%0d left=%0d en=%b%b cmd=%b, want 4 0 00 NOP", done, grant_q.size(), write_en, read_en, sdram_cmd);
        end
    endtask

    task automatic test_refresh_during_read;
        int target;
        target = t_ref + RP;
        while (cyc < target - 5) tick;
        rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick; settle;
            tests_run++;
            if ({read_en, aref_req, sdram_cmd} !== {2'b10, CMD_READ}) begin
                tests_failed++;
                $display("FAIL read_before_ref[%0d]: en/req=%b%b cmd=%b, want 10 %b", k, read_en, aref_req, sdram_cmd, CMD_READ);
            end
        end
        tick; settle;
        tests_run++;
        if ({read_en, aref_req, aref_en} !== 3'b010) begin
            tests_failed++;
            $display("FAIL read_drop_on_ref: read_en/aref_req/aref_en=%b, want 010", {read_en, aref_req, aref_en});
        end
        tick;
        tick;
        read_end = 1'b1;
        rd_req   = 1'b0;
        tick;
        read_end = 1'b0;
        settle;
        tests_run++;
        if ({aref_en, write_en, read_en, aref_req, sdram_cmd} !== {4'b0001, CMD_NOP}) begin
            tests_failed++;
            $display("FAIL read_end_arbit: en/req=%b cmd=%b, want 0001 NOP", {aref_en, write_en, read_en, aref_req}, sdram_cmd);
        end
        tick; settle;
        tests_run++;
        if (aref_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL ref_after_read: aref_en=%b, want 1", aref_en);
        end
        aref_end = 1'b1;
        tick;
        aref_end = 1'b0;
        settle;
        tests_run++;
        if (aref_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL ref_after_read_clear: aref_req=%b, want 0", aref_req);
        end
        t_ref = target;
    endtask

    task automatic test_overrun;
        wait_ref_rise(t_ref, "ref_third_interval");
        tick;
        while (cyc < t_ref + RP - 1) tick;
        settle;
        tests_run++;
        if ({aref_en, ref_overrun} !== 2'b10) begin
            tests_failed++;
            $display("FAIL overrun_before: aref_en/ref_overrun=%b, want 10", {aref_en, ref_overrun});
        end
        aref_end = 1'b1;
        tick;
        aref_end = 1'b0;
        settle;
        tests_run++;
        if ({aref_en, aref_req, ref_overrun} !== 3'b011) begin
            tests_failed++;
            $display("FAIL wrap_beats_end: aref_en/aref_req/ref_overrun=%b, want 011", {aref_en, aref_req, ref_overrun});
        end
        tick; settle;
        tests_run++;
        if (aref_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_regrant: aref_en=%b, want 1", aref_en);
        end
        aref_end = 1'b1;
        tick;
        aref_end = 1'b0;
        settle;
        tests_run++;
        if ({aref_req, ref_overrun} !== 2'b01) begin
            tests_failed++;
            $display("FAIL overrun_sticky: aref_req/ref_overrun=%b, want 01", {aref_req, ref_overrun});
        end
        wr_req = 1'b1;
    endtask

    task automatic test_reset_mid_write;
        init_cmd  = CMD_NOP;
        init_addr = NOP_ADDR;
        tick; settle;
        tests_run++;
        if ({write_en, dut.last_grant_q} !== 2'b10) begin
            tests_failed++;
            $display("FAIL write_grant: write_en/last_grant=%b, want 10", {write_en, dut.last_grant_q});
        end
        #2;
        RST = 1'b1;
        #1;
        tests_run++;
        if ({aref_en, write_en, read_en, aref_req, ref_overrun} !== 5'b0) begin
            tests_failed++;
            $display("FAIL async_reset_flags: got %b, want 00000", {aref_en, write_en, read_en, aref_req, ref_overrun});
        end
        tests_run++;
        if (dut.state_q !== ST_INIT || dut.u_timer.cnt_q !== 7'd0 || dut.last_grant_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset_state: state=%0d cnt=%0d last_grant=%b, want 0 0 1", dut.state_q, dut.u_timer.cnt_q, dut.last_grant_q);
        end
        tests_run++;
        if ({sdram_cmd, sdram_addr} !== {CMD_NOP, NOP_ADDR}) begin
            tests_failed++;
            $display("FAIL async_reset_bus: got %b/%h, want %b/%h", sdram_cmd, sdram_addr, CMD_NOP, NOP_ADDR);
        end
        wr_req    = 1'b0;
        init_done = 1'b0;
        tick;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_init;
        test_refresh_idle;
        test_back_to_back;
        test_refresh_during_read;
        test_overrun;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
